bcd_updown_counter: RTL and testbench

BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

---
 rtl/bcd_updown_counter.sv | 90 +++++++++
 tb/tb_bcd_updown_counter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter.sv
// Multi-digit packed-BCD up/down counter with parallel load, wrap or saturate at
// the limits, a registered carry pulse and a sticky invalid-load flag.
module bcd_updown_counter #(
  parameter int DIGITS   = 2,
  parameter bit SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  carry_out,
  output logic                  at_limit,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]      count_q, count_d, step_val;
  logic              carry_q, carry_d;
  logic              load_err_q, load_err_d;
  logic [DIGITS:0]   up_prop, dn_prop;
  logic [DIGITS-1:0] bad_digit;
  logic              all_nine, all_zero, limit_hit, load_ok;

  // up_prop[i]/dn_prop[i]: every digit below i is 9 / 0, so digit i must step.
  assign up_prop[0] = 1'b1;
  assign dn_prop[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] dig;
      logic [3:0] nxt;

      assign dig            = count_q[4*gi +: 4];
      assign up_prop[gi+1]  = up_prop[gi] & (dig == 4'd9);
      assign dn_prop[gi+1]  = dn_prop[gi] & (dig == 4'd0);
      assign bad_digit[gi]  = (load_val[4*gi +: 4] > 4'd9);

      always_comb begin
        nxt = dig;
        if (!dir) begin
          if (up_prop[gi]) nxt = (dig == 4'd9) ? 4'd0 : 4'(dig + 4'd1);
        end else begin
          if (dn_prop[gi]) nxt = (dig == 4'd0) ? 4'd9 : 4'(dig - 4'd1);
        end
      end

      assign step_val[4*gi +: 4] = nxt;
    end
  endgenerate

  assign all_nine  = up_prop[DIGITS];
  assign all_zero  = dn_prop[DIGITS];
  assign limit_hit = dir ? all_zero : all_nine;
  assign load_ok   = ~(|bad_digit);

  always_comb begin
    count_d    = count_q;
    carry_d    = 1'b0;
    load_err_d = load_err_q;
    if (load) begin
      load_err_d = ~load_ok;
      if (load_ok) count_d = load_val;
    end else if (en) begin
      carry_d = limit_hit;
      if (!(limit_hit && SATURATE)) count_d = step_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      carry_q    <= carry_d;
      load_err_q <= load_err_d;
    end
  end

  assign count     = count_q;
  assign carry_out = carry_q;
  assign load_err  = load_err_q;
  assign at_limit  = limit_hit;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Checks three counter configurations (2-digit wrap, 2-digit saturate, 4-digit wrap)
// against an integer-arithmetic reference model, directed cases then random traffic.
module tb_bcd_updown_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, dir = 1'b0, load = 1'b0;
  logic [7:0]  ld8 = '0;
  logic [15:0] ld16 = '0;

  logic [7:0]  cnt0, cnt1;
  logic [15:0] cnt2;
  logic        car0, car1, car2, atl0, atl1, atl2, err0, err1, err2;

  int errors = 0;
  int checks = 0;

  int mval[3];
  bit mcar[3];
  bit merr[3];
  int nd[3]  = '{2, 2, 4};
  bit sat[3] = '{1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(2), .SATURATE(1'b0)) u_wrap2 (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load), .load_val(ld8),
    .count(cnt0), .carry_out(car0), .at_limit(atl0), .load_err(err0));
  bcd_updown_counter #(.DIGITS(2), .SATURATE(1'b1)) u_sat2 (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load), .load_val(ld8),
    .count(cnt1), .carry_out(car1), .at_limit(atl1), .load_err(err1));
  bcd_updown_counter #(.DIGITS(4), .SATURATE(1'b0)) u_wrap4 (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load), .load_val(ld16),
    .count(cnt2), .carry_out(car2), .at_limit(atl2), .load_err(err2));

  function automatic int max_of(input int d);
    int m = 1;
    for (int i = 0; i < d; i++) m = m * 10;
    return m - 1;
  endfunction

  function automatic logic [31:0] to_bcd(input int v, input int d);
    logic [31:0] r = '0;
    int x = v;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] dut_cnt(input int k);
    case (k)
      0: return {24'd0, cnt0};
      1: return {24'd0, cnt1};
      default: return {16'd0, cnt2};
    endcase
  endfunction

  function automatic logic dut_car(input int k);
    return (k == 0) ? car0 : (k == 1) ? car1 : car2;
  endfunction

  function automatic logic dut_atl(input int k);
    return (k == 0) ? atl0 : (k == 1) ? atl1 : atl2;
  endfunction

  function automatic logic dut_err(input int k);
    return (k == 0) ? err0 : (k == 1) ? err1 : err2;
  endfunction

  task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s inst=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  // Reference behaviour in plain decimal arithmetic.
  task automatic model_update(input int k, input bit e, input bit d, input bit l, input logic [31:0] lv);
    int mx = max_of(nd[k]);
    int v = 0;
    bit ok = 1'b1;
    mcar[k] = 1'b0;
    if (l) begin
      for (int i = nd[k] - 1; i >= 0; i--) begin
        if (lv[4*i +: 4] > 4'd9) ok = 1'b0;
        v = v * 10 + int'(lv[4*i +: 4]);
      end
      merr[k] = !ok;
      if (ok) mval[k] = v;
    end else if (e) begin
      if (!d) begin
        if (mval[k] == mx) begin mcar[k] = 1'b1; mval[k] = sat[k] ? mx : 0; end
        else mval[k] = mval[k] + 1;
      end else begin
        if (mval[k] == 0) begin mcar[k] = 1'b1; mval[k] = sat[k] ? 0 : mx; end
        else mval[k] = mval[k] - 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      check({tag, ".count"}, k, dut_cnt(k), to_bcd(mval[k], nd[k]));
      check({tag, ".carry"}, k, {31'd0, dut_car(k)}, {31'd0, mcar[k]});
      check({tag, ".err"},   k, {31'd0, dut_err(k)}, {31'd0, merr[k]});
    end
  endtask

  // Entered and left at posedge+1.
  task automatic step(input string tag, input bit e, input bit d, input bit l,
                      input logic [7:0] v8, input logic [15:0] v16);
    en = e; dir = d; load = l; ld8 = v8; ld16 = v16;
    #1;
    for (int k = 0; k < 3; k++) begin
      bit lim = d ? (mval[k] == 0) : (mval[k] == max_of(nd[k]));
      check({tag, ".at_limit"}, k, {31'd0, dut_atl(k)}, {31'd0, lim});
    end
    for (int k = 0; k < 3; k++)
      model_update(k, e, d, l, (k == 2) ? {16'd0, v16} : {24'd0, v8});
    @(posedge clk);
    #1;
    check_all(tag);
    $display("step %-10s en=%0b dir=%0b load=%0b ld8=%h ld16=%h -> %h %h %h car=%0b%0b%0b err=%0b%0b%0b",
             tag, e, d, l, v8, v16, cnt0, cnt1, cnt2, car0, car1, car2, err0, err1, err2);
  endtask

  // Reset pulsed between edges; the edge after release sees idle inputs.
  task automatic mid_reset(input string tag);
    en = 1'b0; load = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin mval[k] = 0; mcar[k] = 1'b0; merr[k] = 1'b0; end
    check_all(tag);
    $display("reset %-9s -> %h %h %h", tag, cnt0, cnt1, cnt2);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  r8;
    logic [15:0] r16;
    bit re, rd, rl;

    for (int k = 0; k < 3; k++) begin mval[k] = 0; mcar[k] = 1'b0; merr[k] = 1'b0; end
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    step("ld09", 0, 0, 1, 8'h09, 16'h0999);
    step("up", 1, 0, 0, 8'h00, 16'h0000);
    check("ripple2", 0, {24'd0, cnt0}, 32'h10);
    check("ripple4", 2, {16'd0, cnt2}, 32'h1000);
    step("down", 1, 1, 0, 8'h00, 16'h0000);
    check("unripple4", 2, {16'd0, cnt2}, 32'h0999);

    step("ld99", 0, 0, 1, 8'h99, 16'h9999);
    step("up_lim", 1, 0, 0, 8'h00, 16'h0000);
    check("wrap_up", 0, {24'd0, cnt0}, 32'h00);
    check("wrap_car", 0, {31'd0, car0}, 32'd1);
    step("idle", 0, 0, 0, 8'h00, 16'h0000);
    for (int i = 0; i < 3; i++) step("sat_up", 1, 0, 0, 8'h00, 16'h0000);
    check("sat_hold", 1, {24'd0, cnt1}, 32'h99);

    step("ld00", 0, 1, 1, 8'h00, 16'h0000);
    check("atl_down", 0, {31'd0, atl0}, 32'd1);
    step("dn_lim", 1, 1, 0, 8'h00, 16'h0000);
    check("wrap_dn", 0, {24'd0, cnt0}, 32'h99);
    check("sat_dn", 1, {24'd0, cnt1}, 32'h00);
    step("ld10", 0, 1, 1, 8'h10, 16'h0010);
    step("dn10", 1, 1, 0, 8'h00, 16'h0000);

    step("ld42", 0, 0, 1, 8'h42, 16'h0042);
    step("ld3A", 0, 0, 1, 8'h3A, 16'h003A);
    check("bad_hold", 0, {24'd0, cnt0}, 32'h42);
    step("idle_err", 0, 0, 0, 8'h00, 16'h0000);
    step("ld57_en", 1, 0, 1, 8'h57, 16'h0057);
    check("prio", 0, {24'd0, cnt0}, 32'h57);

    step("ld37", 0, 0, 1, 8'h37, 16'h0037);
    step("ldbad", 0, 0, 1, 8'hF0, 16'hF000);
    mid_reset("mid_rst");
    step("post_rst", 1, 0, 0, 8'h00, 16'h0000);
    check("post_rst", 0, {24'd0, cnt0}, 32'h01);

    for (int it = 0; it < 400; it++) begin
      re = 1'($urandom_range(0, 3) != 0);
      rd = 1'($urandom_range(0, 1));
      rl = 1'($urandom_range(0, 7) == 0);
      r8 = 8'($urandom);
      r16 = 16'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        r8  = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        r16 = to_bcd($urandom_range(0, 9999), 4);
      end
      if ($urandom_range(0, 9) == 0) begin
        r8  = rd ? 8'h00 : 8'h99;
        r16 = rd ? 16'h0000 : 16'h9999;
        rl  = 1'b1;
      end
      if ($urandom_range(0, 59) == 0) mid_reset("rnd_rst");
      else step("rnd", re, rd, rl, r8, r16);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
